// File: rtl/switch_debounce_pkg.sv
// Shared constants and types for the switch debounce block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the default qualification time, the per-channel FSM encoding and a
// helper that turns a debounce time in milliseconds into clock cycles.
package switch_debounce_pkg;

    // System clock frequency the defaults are derived from.
    localparam int unsigned CLK_HZ = 100_000_000;

    // 10 ms at CLK_HZ.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // IDLE: synchronised level matches the clean level.
    // CHECK: a different level is being qualified.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } db_state_e;

    // Convert a debounce time in milliseconds into clock cycles at CLK_HZ.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One-bit switch conditioner: 2-flop synchroniser, qualification counter, edge pulses.
// Latency: clean level changes DEBOUNCE_CYCLES+1 edges after the first synchroniser sample of a steady new level.
// Backpressure: none; free-running, outputs are registered levels/pulses.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   switch_raw   raw switch pin, asynchronous to clk
//   switch_clean debounced level
//   switch_rise  one-cycle pulse, coincident with switch_clean going 0->1
//   switch_fall  one-cycle pulse, coincident with switch_clean going 1->0
module switch_debounce_channel
    import switch_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch_raw,
    output logic switch_clean,
    output logic switch_rise,
    output logic switch_fall
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value at which the candidate level has persisted long enough.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    // Two-flop synchroniser; s1 may go metastable, only s2 is used by logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= switch_raw;
            s2_q <= s1_q;
        end
    end

    // Qualification FSM. Entering CHECK already counts the first cycle of the
    // new level, so acceptance happens when cnt reaches DEBOUNCE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s2_q != clean_q) begin
                    state_d = ST_CHECK;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (s2_q == clean_q) begin
                    // Level fell back before qualifying: discard progress.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    clean_d = s2_q;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign switch_clean = clean_q;
    assign switch_rise  = rise_q;
    assign switch_fall  = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch conditioner: WIDTH independent synchronise+debounce channels.
// Latency: clean level changes DEBOUNCE_CYCLES+1 edges after the first synchroniser sample of a steady new level.
// Backpressure: none; outputs are registered levels and one-cycle pulses.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   switch_raw   raw switch pins, asynchronous to clk
//   switch_clean debounced level per channel
//   switch_rise  per-channel one-cycle pulse on clean 0->1
//   switch_fall  per-channel one-cycle pulse on clean 1->0
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_clean,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall
);

    // The counter scheme needs at least one CHECK cycle before acceptance.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("switch_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        switch_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_channel (
            .clk          (clk),
            .rst_n        (rst_n),
            .switch_raw   (switch_raw[i]),
            .switch_clean (switch_clean[i]),
            .switch_rise  (switch_rise[i]),
            .switch_fall  (switch_fall[i])
        );
    end

endmodule
